execute_slice_seq: RTL and testbench

- Multi-cycle sequencer for the execute stage. It accepts one 128-bit execute operation through a valid/ready handshake.
- It runs the operation through a narrow SLICE_W-bit slice ALU, one slice per cycle, least-significant slice first, chaining carry between slices.
- It returns the full result, zero flag and branch target through a second handshake.
- It sits between decode/issue and memory/writeback and trades throughput for ALU area.

---
 rtl/execute_slice_seq_pkg.sv | 27 ++
 rtl/execute_slice_seq_if.sv | 45 ++++
 rtl/execute_slice_seq_slice_alu.sv | 46 ++++
 rtl/execute_slice_seq.sv | 179 +++++++++++++++++
 tb/tb_execute_slice_seq.sv | 278 +++++++++++++++++++++++++++
 5 files changed

// File: rtl/execute_slice_seq_pkg.sv
// -----------------------------------------------------------------------------
// execute_seq_pkg
// Shared types and default widths for the slice-serial execute sequencer.
//   alu_op_t    : operation encoding carried on alu_control
//   seq_state_t : sequencer FSM states
//   *_DEF       : default widths used by the interface, top and slice ALU
// -----------------------------------------------------------------------------
package execute_seq_pkg;

  localparam int DATA_W_DEF  = 128;
  localparam int SLICE_W_DEF = 32;
  localparam int PC_W_DEF    = 15;

  typedef enum logic [1:0] {
    ALU_ADD = 2'b00,
    ALU_SUB = 2'b01,
    ALU_AND = 2'b10,
    ALU_OR  = 2'b11
  } alu_op_t;

  typedef enum logic [1:0] {
    S_IDLE = 2'b00,
    S_RUN  = 2'b01,
    S_DONE = 2'b10
  } seq_state_t;

endpackage

// File: rtl/execute_slice_seq_if.sv
// -----------------------------------------------------------------------------
// execute_slice_seq_if
// Request/response bundle between issue, the execute sequencer and writeback.
//   request  : in_valid/in_ready, rd1, rd2, alu_control, add1_sel, mem_sel,
//              pc_8, branch
//   response : out_valid/out_ready, alu_out, zero_flag, add_8_out
//   status   : busy
// slave modport is the sequencer side, master modport the requester side.
// -----------------------------------------------------------------------------
interface execute_slice_seq_if
  import execute_seq_pkg::*;
#(
  parameter int DATA_W = DATA_W_DEF,
  parameter int PC_W   = PC_W_DEF
) ();

  logic              in_valid;
  logic              in_ready;
  logic [DATA_W-1:0] rd1;
  logic [DATA_W-1:0] rd2;
  logic [1:0]        alu_control;
  logic              add1_sel;
  logic              mem_sel;
  logic [PC_W-1:0]   pc_8;
  logic [PC_W-1:0]   branch;
  logic              out_valid;
  logic              out_ready;
  logic [DATA_W-1:0] alu_out;
  logic              zero_flag;
  logic [PC_W-1:0]   add_8_out;
  logic              busy;

  modport slave (
    input  in_valid, rd1, rd2, alu_control, add1_sel, mem_sel, pc_8, branch,
    input  out_ready,
    output in_ready, out_valid, alu_out, zero_flag, add_8_out, busy
  );

  modport master (
    output in_valid, rd1, rd2, alu_control, add1_sel, mem_sel, pc_8, branch,
    output out_ready,
    input  in_ready, out_valid, alu_out, zero_flag, add_8_out, busy
  );

endinterface

// File: rtl/execute_slice_seq_slice_alu.sv
// -----------------------------------------------------------------------------
// slice_alu
// Purely combinational W-bit ALU slice, reused once per cycle by the sequencer.
//   a_i, b_i : operand slices
//   op_i     : ADD / SUB / AND / OR
//   cin_i    : carry in from the previous (less significant) slice
//   y_o      : slice result
//   cout_o   : carry out (ADD/SUB only, 0 for logic ops)
// -----------------------------------------------------------------------------
module slice_alu
  import execute_seq_pkg::*;
#(
  parameter int W = SLICE_W_DEF
) (
  input  logic [W-1:0] a_i,
  input  logic [W-1:0] b_i,
  input  alu_op_t      op_i,
  input  logic         cin_i,
  output logic [W-1:0] y_o,
  output logic         cout_o
);

  logic [W-1:0] b_eff_s;
  logic [W:0]   sum_s;

  // Slice arithmetic: SUB is a + ~b + cin, the sequencer seeds cin=1 on slice 0
  always_comb begin
    b_eff_s = (op_i == ALU_SUB) ? ~b_i : b_i;
    sum_s   = {1'b0, a_i} + {1'b0, b_eff_s} + {{W{1'b0}}, cin_i};
    y_o     = '0;
    cout_o  = 1'b0;
    case (op_i)
      ALU_ADD, ALU_SUB: begin
        y_o    = sum_s[W-1:0];
        cout_o = sum_s[W];
      end
      ALU_AND: y_o = a_i & b_i;
      ALU_OR:  y_o = a_i | b_i;
      default: begin
        y_o    = '0;
        cout_o = 1'b0;
      end
    endcase
  end

endmodule

// File: rtl/execute_slice_seq.sv
// -----------------------------------------------------------------------------
// execute_slice_seq
// Multi-cycle execute stage: latches one DATA_W-bit operation, runs it through
// a single SLICE_W-bit ALU one slice per cycle (LSB slice first, carry chained),
// then presents result, zero flag and branch target until consumed.
//   clk, rst : clock, asynchronous active-high reset
//   bus      : execute_slice_seq_if.slave (request, response and busy status)
// -----------------------------------------------------------------------------
module execute_slice_seq
  import execute_seq_pkg::*;
#(
  parameter int DATA_W  = DATA_W_DEF,
  parameter int SLICE_W = SLICE_W_DEF,
  parameter int PC_W    = PC_W_DEF
) (
  input  logic                clk,
  input  logic                rst,
  execute_slice_seq_if.slave  bus
);

  localparam int NSLICE = DATA_W / SLICE_W;
  localparam int CNT_W  = (NSLICE > 1) ? $clog2(NSLICE) : 1;
  localparam logic [CNT_W-1:0] LAST_CNT = CNT_W'(NSLICE - 1);

  seq_state_t        state_q, state_d;
  logic [DATA_W-1:0] a_q, a_d;
  logic [DATA_W-1:0] b_q, b_d;
  alu_op_t           op_q, op_d;
  logic [CNT_W-1:0]  cnt_q, cnt_d;
  logic              carry_q, carry_d;
  logic [DATA_W-1:0] result_q, result_d;
  logic              zero_q, zero_d;
  logic [PC_W-1:0]   add8_q, add8_d;
  logic              in_ready_q, in_ready_d;
  logic              out_valid_q, out_valid_d;
  logic              busy_q, busy_d;

  logic [SLICE_W-1:0] a_slice_s;
  logic [SLICE_W-1:0] b_slice_s;
  logic [SLICE_W-1:0] y_s;
  logic               cout_s;
  logic [DATA_W-1:0]  merged_s;

  // Operand B source: memory addressing forces 0 and wins over the +1 select
  function automatic logic [DATA_W-1:0] pick_b(input logic mem_sel,
                                                input logic add1_sel,
                                                input logic [DATA_W-1:0] rd2);
    logic [DATA_W-1:0] b;
    if (mem_sel) begin
      b = '0;
    end else if (add1_sel) begin
      b = {{(DATA_W-1){1'b0}}, 1'b1};
    end else begin
      b = rd2;
    end
    return b;
  endfunction

  // Select the operand slices addressed by the slice counter
  always_comb begin
    a_slice_s = '0;
    b_slice_s = '0;
    for (int k = 0; k < NSLICE; k++) begin
      a_slice_s = (cnt_q == CNT_W'(k)) ? a_q[k*SLICE_W +: SLICE_W] : a_slice_s;
      b_slice_s = (cnt_q == CNT_W'(k)) ? b_q[k*SLICE_W +: SLICE_W] : b_slice_s;
    end
  end

  slice_alu #(.W(SLICE_W)) u_slice_alu (
    .a_i    (a_slice_s),
    .b_i    (b_slice_s),
    .op_i   (op_q),
    .cin_i  (carry_q),
    .y_o    (y_s),
    .cout_o (cout_s)
  );

  // Result register with the current slice merged in
  always_comb begin
    merged_s = result_q;
    for (int k = 0; k < NSLICE; k++) begin
      merged_s[k*SLICE_W +: SLICE_W] = (cnt_q == CNT_W'(k)) ? y_s
                                                            : merged_s[k*SLICE_W +: SLICE_W];
    end
  end

  // FSM next state and datapath next values
  always_comb begin
    state_d  = state_q;
    a_d      = a_q;
    b_d      = b_q;
    op_d     = op_q;
    cnt_d    = cnt_q;
    carry_d  = carry_q;
    result_d = result_q;
    zero_d   = zero_q;
    add8_d   = add8_q;
    case (state_q)
      S_IDLE: begin
        // in_ready is high exactly in IDLE, so in_valid alone completes the handshake
        if (bus.in_valid) begin
          a_d      = bus.rd1;
          b_d      = pick_b(bus.mem_sel, bus.add1_sel, bus.rd2);
          op_d     = alu_op_t'(bus.alu_control);
          add8_d   = bus.pc_8 + bus.branch;
          result_d = '0;
          cnt_d    = '0;
          carry_d  = (alu_op_t'(bus.alu_control) == ALU_SUB);
          state_d  = S_RUN;
        end else begin
          state_d  = S_IDLE;
        end
      end
      S_RUN: begin
        result_d = merged_s;
        carry_d  = cout_s;
        if (cnt_q == LAST_CNT) begin
          // Final carry is dropped: results wrap modulo 2^DATA_W
          cnt_d   = '0;
          zero_d  = (merged_s == '0);
          state_d = S_DONE;
        end else begin
          cnt_d   = cnt_q + CNT_W'(1);
        end
      end
      S_DONE: begin
        if (bus.out_ready) begin
          state_d = S_IDLE;
        end else begin
          state_d = S_DONE;
        end
      end
      default: state_d = S_IDLE;
    endcase
    // Handshake/status flags are registered copies of the next state
    in_ready_d  = (state_d == S_IDLE);
    out_valid_d = (state_d == S_DONE);
    busy_d      = (state_d != S_IDLE);
  end

  // State, datapath and output registers
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q     <= S_IDLE;
      a_q         <= '0;
      b_q         <= '0;
      op_q        <= ALU_ADD;
      cnt_q       <= '0;
      carry_q     <= 1'b0;
      result_q    <= '0;
      zero_q      <= 1'b0;
      add8_q      <= '0;
      in_ready_q  <= 1'b1;
      out_valid_q <= 1'b0;
      busy_q      <= 1'b0;
    end else begin
      state_q     <= state_d;
      a_q         <= a_d;
      b_q         <= b_d;
      op_q        <= op_d;
      cnt_q       <= cnt_d;
      carry_q     <= carry_d;
      result_q    <= result_d;
      zero_q      <= zero_d;
      add8_q      <= add8_d;
      in_ready_q  <= in_ready_d;
      out_valid_q <= out_valid_d;
      busy_q      <= busy_d;
    end
  end

  assign bus.in_ready  = in_ready_q;
  assign bus.out_valid = out_valid_q;
  assign bus.busy      = busy_q;
  assign bus.alu_out   = result_q;
  assign bus.zero_flag = zero_q;
  assign bus.add_8_out = add8_q;

endmodule

// File: tb/tb_execute_slice_seq.sv
// -----------------------------------------------------------------------------
// tb_execute_slice_seq
// Self-checking bench: reset values, a table of directed operations with
// latency/hold checks, reset during RUN, back-to-back issue, and a randomized
// stream scored against a whole-word arithmetic reference model.
// -----------------------------------------------------------------------------
module tb_execute_slice_seq;

  logic clk;
  logic rst;
  int   checks;
  int   errors;

  execute_slice_seq_if bus ();

  execute_slice_seq dut (
    .clk (clk),
    .rst (rst),
    .bus (bus)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  typedef struct {
    logic [127:0] rd1;
    logic [127:0] rd2;
    logic [1:0]   ctl;
    logic         add1;
    logic         mem;
    logic [14:0]  pc;
    logic [14:0]  br;
    int           hold;
    logic [127:0] exp_out;
    logic         exp_zero;
    logic [14:0]  exp_a8;
  } vec_t;

  typedef struct {
    logic [127:0] res;
    logic         z;
    logic [14:0]  a8;
  } exp_t;

  vec_t vecs [10];

  task automatic chk(input string name, input logic [127:0] act, input logic [127:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %h expected %h", name, act, exp);
    end
  endtask

  task automatic chki(input string name, input int act, input int exp);
    checks++;
    if (act != exp) begin
      errors++;
      $display("FAIL %s: got %0d expected %0d", name, act, exp);
    end
  endtask

  // Reference: whole-word arithmetic, no slicing
  function automatic logic [127:0] model_res(input logic [127:0] a, input logic [127:0] r2,
                                             input logic [1:0] c, input logic add1,
                                             input logic mem);
    logic [127:0] b;
    b = mem ? 128'd0 : (add1 ? 128'd1 : r2);
    case (c)
      2'b00:   return a + b;
      2'b01:   return a - b;
      2'b10:   return a & b;
      default: return a | b;
    endcase
  endfunction

  function automatic logic [127:0] rand128();
    return {$urandom, $urandom, $urandom, $urandom};
  endfunction

  task automatic drive_op(input logic [127:0] r1, input logic [127:0] r2, input logic [1:0] c,
                          input logic a1, input logic m, input logic [14:0] pc,
                          input logic [14:0] br);
    bus.rd1 = r1; bus.rd2 = r2; bus.alu_control = c;
    bus.add1_sel = a1; bus.mem_sel = m; bus.pc_8 = pc; bus.branch = br;
  endtask

  task automatic scramble();
    drive_op(rand128(), rand128(), 2'($urandom_range(0, 3)), 1'($urandom_range(0, 1)),
             1'($urandom_range(0, 1)), 15'($urandom), 15'($urandom));
  endtask

  // One directed operation: latency, result, hold under back-pressure, release
  task automatic run_vec(input vec_t v, input int idx);
    int lat;
    @(negedge clk);
    chk($sformatf("v%0d_in_ready_idle", idx), 128'(bus.in_ready), 128'd1);
    drive_op(v.rd1, v.rd2, v.ctl, v.add1, v.mem, v.pc, v.br);
    bus.in_valid  = 1'b1;
    bus.out_ready = (v.hold == 0);
    @(negedge clk);
    bus.in_valid = 1'b0;
    scramble();
    chk($sformatf("v%0d_busy_run", idx), 128'(bus.busy), 128'd1);
    lat = 1;
    while (!bus.out_valid && lat < 20) begin
      @(negedge clk);
      lat++;
    end
    chki($sformatf("v%0d_latency", idx), lat, 5);
    chk($sformatf("v%0d_alu_out", idx), bus.alu_out, v.exp_out);
    chk($sformatf("v%0d_zero", idx), 128'(bus.zero_flag), 128'(v.exp_zero));
    chk($sformatf("v%0d_add8", idx), 128'(bus.add_8_out), 128'(v.exp_a8));
    for (int h = 0; h < v.hold; h++) begin
      @(negedge clk);
      chk($sformatf("v%0d_hold%0d_valid", idx, h), 128'(bus.out_valid), 128'd1);
      chk($sformatf("v%0d_hold%0d_in_ready", idx, h), 128'(bus.in_ready), 128'd0);
      chk($sformatf("v%0d_hold%0d_out", idx, h), bus.alu_out, v.exp_out);
      chk($sformatf("v%0d_hold%0d_add8", idx, h), 128'(bus.add_8_out), 128'(v.exp_a8));
    end
    bus.out_ready = 1'b1;
    @(negedge clk);
    chk($sformatf("v%0d_valid_drop", idx), 128'(bus.out_valid), 128'd0);
    chk($sformatf("v%0d_idle_ready", idx), 128'(bus.in_ready), 128'd1);
    chk($sformatf("v%0d_idle_keep", idx), bus.alu_out, v.exp_out);
    bus.out_ready = 1'b0;
  endtask

  initial begin
    #2000000;
    $display("FAIL watchdog: got timeout expected completion");
    $fatal(1, "watchdog expired");
  end

  initial begin
    int   acc_n [$];
    logic [127:0] res_q [$];
    logic [127:0] opa1, opa2, opb1, opb2;
    exp_t q [$];
    exp_t e;
    int   sent, got, drop_next, saw_valid;
    logic hold_pend;
    logic [127:0] h_out;
    logic h_z;
    logic [14:0] h_a8;
    localparam int NR = 40;

    checks = 0;
    errors = 0;
    //         rd1                                          rd2                                          ctl    a1    m     pc        br        hold exp_out                                      z     a8
    vecs[0] = '{128'hFFFF_FFFF,                             128'd1,                                      2'b00, 1'b0, 1'b0, 15'h0100, 15'h0020, 0, 128'h1_0000_0000,                            1'b0, 15'h0120};
    vecs[1] = '{128'd0,                                     128'd1,                                      2'b01, 1'b0, 1'b0, 15'h0000, 15'h0000, 0, {128{1'b1}},                                 1'b0, 15'h0000};
    vecs[2] = '{128'h1234_5678_9ABC_DEF0_0F0F_F0F0_AAAA_5555, 128'h1234_5678_9ABC_DEF0_0F0F_F0F0_AAAA_5555, 2'b01, 1'b0, 1'b0, 15'h1234, 15'h0001, 0, 128'd0,                                      1'b1, 15'h1235};
    vecs[3] = '{128'hA0,                                    128'h55,                                     2'b11, 1'b1, 1'b1, 15'h0010, 15'h0010, 0, 128'hA0,                                     1'b0, 15'h0020};
    vecs[4] = '{128'hA0,                                    128'h55,                                     2'b11, 1'b1, 1'b0, 15'h0010, 15'h0011, 0, 128'hA1,                                     1'b0, 15'h0021};
    vecs[5] = '{128'd5,                                     128'd7,                                      2'b00, 1'b0, 1'b0, 15'h7FF8, 15'h0010, 3, 128'hC,                                      1'b0, 15'h0008};
    vecs[6] = '{{128{1'b1}},                                128'd1,                                      2'b00, 1'b0, 1'b0, 15'h0001, 15'h7FFF, 0, 128'd0,                                      1'b1, 15'h0000};
    vecs[7] = '{128'h1_0000_0000_0000_0000,                 128'd1,                                      2'b01, 1'b0, 1'b0, 15'h0002, 15'h0003, 0, 128'hFFFF_FFFF_FFFF_FFFF,                    1'b0, 15'h0005};
    vecs[8] = '{{32{4'hF}},                                 {32{4'h0}},                                  2'b10, 1'b0, 1'b0, 15'h0004, 15'h0004, 0, 128'd0,                                      1'b1, 15'h0008};
    vecs[9] = '{128'd5,                                     128'd3,                                      2'b01, 1'b1, 1'b1, 15'h4000, 15'h4000, 2, 128'd5,                                      1'b0, 15'h0000};

    bus.in_valid  = 1'b0;
    bus.out_ready = 1'b0;
    drive_op(128'd0, 128'd0, 2'b00, 1'b0, 1'b0, 15'd0, 15'd0);
    rst = 1'b1;
    repeat (2) @(negedge clk);
    chk("rst_in_ready", 128'(bus.in_ready), 128'd1);
    chk("rst_out_valid", 128'(bus.out_valid), 128'd0);
    chk("rst_busy", 128'(bus.busy), 128'd0);
    chk("rst_alu_out", bus.alu_out, 128'd0);
    chk("rst_zero", 128'(bus.zero_flag), 128'd0);
    chk("rst_add8", 128'(bus.add_8_out), 128'd0);
    rst = 1'b0;

    for (int i = 0; i < 10; i++) run_vec(vecs[i], i);

    // Reset two cycles into RUN abandons the operation
    @(negedge clk);
    drive_op(128'd9, 128'd4, 2'b00, 1'b0, 1'b0, 15'h0011, 15'h0022);
    bus.in_valid  = 1'b1;
    bus.out_ready = 1'b1;
    @(negedge clk);
    bus.in_valid = 1'b0;
    @(negedge clk);
    rst = 1'b1;
    #1;
    chk("mid_rst_in_ready", 128'(bus.in_ready), 128'd1);
    chk("mid_rst_out_valid", 128'(bus.out_valid), 128'd0);
    chk("mid_rst_busy", 128'(bus.busy), 128'd0);
    chk("mid_rst_alu_out", bus.alu_out, 128'd0);
    chk("mid_rst_add8", 128'(bus.add_8_out), 128'd0);
    @(negedge clk);
    rst = 1'b0;
    saw_valid = 0;
    for (int n = 0; n < 10; n++) begin
      @(negedge clk);
      if (bus.out_valid) saw_valid++;
    end
    chki("mid_rst_no_valid", saw_valid, 0);
    bus.out_ready = 1'b0;
    run_vec(vecs[0], 10);

    // Back-to-back: in_valid held, second op's operands change during RUN
    opa1 = rand128(); opa2 = rand128(); opb1 = rand128(); opb2 = rand128();
    @(negedge clk);
    drive_op(opa1, opa2, 2'b00, 1'b0, 1'b0, 15'd1, 15'd2);
    bus.in_valid  = 1'b1;
    bus.out_ready = 1'b1;
    for (int n = 0; n < 25; n++) begin
      if (n > 0) @(negedge clk);
      if (acc_n.size() == 1 && n == acc_n[0] + 1)
        drive_op(opb1, opb2, 2'b01, 1'b0, 1'b0, 15'd3, 15'd4);
      if (acc_n.size() == 2 && n == acc_n[1] + 1) begin
        bus.in_valid = 1'b0;
        scramble();
      end
      if (bus.in_valid && bus.in_ready) acc_n.push_back(n);
      if (bus.out_valid && bus.out_ready) res_q.push_back(bus.alu_out);
    end
    chki("b2b_accepts", acc_n.size(), 2);
    chki("b2b_interval", (acc_n.size() == 2) ? acc_n[1] - acc_n[0] : -1, 6);
    chki("b2b_results", res_q.size(), 2);
    chk("b2b_res0", (res_q.size() > 0) ? res_q[0] : 128'hX, model_res(opa1, opa2, 2'b00, 1'b0, 1'b0));
    chk("b2b_res1", (res_q.size() > 1) ? res_q[1] : 128'hX, model_res(opb1, opb2, 2'b01, 1'b0, 1'b0));
    bus.out_ready = 1'b0;

    // Randomized stream with random gaps and back-pressure
    sent = 0; got = 0; drop_next = 0; hold_pend = 1'b0;
    h_out = '0; h_z = 1'b0; h_a8 = '0;
    for (int n = 0; n < 4000 && got < NR; n++) begin
      @(negedge clk);
      if (hold_pend) begin
        chk("rnd_hold_valid", 128'(bus.out_valid), 128'd1);
        chk("rnd_hold_out", bus.alu_out, h_out);
        chk("rnd_hold_zero", 128'(bus.zero_flag), 128'(h_z));
        chk("rnd_hold_add8", 128'(bus.add_8_out), 128'(h_a8));
      end
      if (drop_next != 0) begin
        bus.in_valid = 1'b0;
        drop_next = 0;
      end
      if (!bus.in_valid) begin
        scramble();
        if ($urandom_range(0, 7) == 0) bus.rd2 = bus.rd1;
        bus.in_valid = (sent < NR) && ($urandom_range(0, 2) != 0);
      end
      bus.out_ready = ($urandom_range(0, 2) != 0);
      if (bus.in_valid && bus.in_ready) begin
        e.res = model_res(bus.rd1, bus.rd2, bus.alu_control, bus.add1_sel, bus.mem_sel);
        e.z   = (e.res == 128'd0);
        e.a8  = bus.pc_8 + bus.branch;
        q.push_back(e);
        sent++;
        drop_next = 1;
      end
      if (bus.out_valid && bus.out_ready) begin
        if (q.size() == 0) begin
          chki("rnd_unexpected_out", 1, 0);
        end else begin
          e = q.pop_front();
          chk("rnd_alu_out", bus.alu_out, e.res);
          chk("rnd_zero", 128'(bus.zero_flag), 128'(e.z));
          chk("rnd_add8", 128'(bus.add_8_out), 128'(e.a8));
        end
        got++;
      end
      hold_pend = bus.out_valid && !bus.out_ready;
      h_out = bus.alu_out;
      h_z   = bus.zero_flag;
      h_a8  = bus.add_8_out;
    end
    chki("rnd_completed", got, NR);

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
